bram_dump_ctrl: RTL and testbench

BRAM_DUMP_CTRL -- requirements
Module: bram_dump_ctrl

---
 rtl/bram_dump_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_bram_dump_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_dump_ctrl.sv
// ---------------------------------------------------------------------------
// bram_dump_ctrl
//
// Purpose:
//   A command-driven BRAM dumper that sits between a UART and a block RAM.
//   It accepts single-byte commands from the UART receiver. Some commands
//   take a two-byte argument, sent high byte first.
//     CMD_ADDR hi lo : set the dump start address (low ADDR_W bits are used)
//     CMD_LEN  hi lo : set the dump length in bytes (16 bits)
//     CMD_DUMP       : stream `length` bytes from BRAM, starting at
//                      start_addr and wrapping modulo 2^ADDR_W
//     CMD_ABORT      : stop a dump in progress
//   The controller reads one byte per BRAM access and hands it to the UART
//   transmitter. It waits for the transmitter to go idle before it issues
//   the next read.
//
// Ports:
//   clk       in   1       clock
//   reset     in   1       asynchronous, active-high reset
//   rx_byte   in   8       received UART byte, valid when rx_ready=1
//   rx_ready  in   1       one-cycle strobe per received byte
//   tx_byte   out  8       byte to UART transmitter
//   tx_send   out  1       one-cycle send strobe to UART transmitter
//   tx_busy   in   1       transmitter busy; may lag tx_send by one cycle
//   mem_addr  out  ADDR_W  BRAM read address (holds while mem_rd=0)
//   mem_rd    out  1       BRAM read enable; mem_data valid the next cycle
//   mem_data  in   8       BRAM read data
//   active    out  1       high while a dump is in progress
//   done      out  1       one-cycle strobe at end or abort of a dump
// ---------------------------------------------------------------------------
module bram_dump_ctrl #(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] CMD_ADDR  = 8'h41,
    parameter logic [7:0] CMD_LEN   = 8'h4E,
    parameter logic [7:0] CMD_DUMP  = 8'h44,
    parameter logic [7:0] CMD_ABORT = 8'h58
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_send,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              active,
    output logic              done
);

    // After reset the length covers the whole memory, so a bare CMD_DUMP
    // dumps the entire BRAM.
    localparam logic [15:0] LEN_RST = 16'(32'd1 << ADDR_W);

    typedef enum logic [3:0] {
        IDLE,
        ARG_HI,
        ARG_LO,
        RD,
        CAP,
        SEND,
        GUARD,
        WAITTX,
        FIN
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] start_addr;
    logic [15:0]       length;
    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       remain;
    logic [7:0]        arg_hi;
    logic              cmd_is_len;    // the pending argument targets length
    logic              abort_pend;    // abort seen after the byte was sent

    logic        abort_now;
    logic [15:0] remain_dec;
    logic [15:0] arg_word;

    assign abort_now  = rx_ready && (rx_byte == CMD_ABORT);
    assign remain_dec = remain - 16'd1;
    assign arg_word   = {arg_hi, rx_byte};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments, so every always_ff
    // block samples pre-edge values and the blocks cannot race each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        next_state = state;
        tx_send    = 1'b0;
        mem_rd     = 1'b0;
        active     = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (rx_ready) begin
                    if (rx_byte == CMD_ADDR || rx_byte == CMD_LEN) begin
                        next_state = ARG_HI;
                    end else if (rx_byte == CMD_DUMP) begin
                        next_state = (length != 16'd0) ? RD : FIN;
                    end
                end
            end

            // Argument bytes are taken verbatim, even if they match a
            // command code.
            ARG_HI: begin
                if (rx_ready) begin
                    next_state = ARG_LO;
                end
            end

            ARG_LO: begin
                if (rx_ready) begin
                    next_state = IDLE;
                end
            end

            RD: begin
                mem_rd     = 1'b1;
                active     = 1'b1;
                next_state = abort_now ? FIN : CAP;
            end

            CAP: begin
                active     = 1'b1;
                next_state = abort_now ? FIN : SEND;
            end

            SEND: begin
                tx_send    = 1'b1;
                active     = 1'b1;
                next_state = GUARD;
            end

            // The transmitter can raise tx_busy one cycle after tx_send.
            // This state skips that cycle so WAITTX never sees a stale
            // idle signal.
            GUARD: begin
                active     = 1'b1;
                next_state = WAITTX;
            end

            WAITTX: begin
                active = 1'b1;
                if (!tx_busy) begin
                    if (abort_pend || abort_now || remain_dec == 16'd0) begin
                        next_state = FIN;
                    end else begin
                        next_state = RD;
                    end
                end
            end

            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Command registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_is_len <= 1'b0;
            arg_hi     <= 8'h00;
            start_addr <= '0;
            length     <= LEN_RST;
        end else if (rx_ready) begin
            unique case (state)
                IDLE: begin
                    if (rx_byte == CMD_ADDR || rx_byte == CMD_LEN) begin
                        cmd_is_len <= (rx_byte == CMD_LEN);
                    end
                end
                ARG_HI: begin
                    arg_hi <= rx_byte;
                end
                ARG_LO: begin
                    if (cmd_is_len) begin
                        length <= arg_word;
                    end else begin
                        start_addr <= arg_word[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Dump datapath
    // -----------------------------------------------------------------------
    // A dump works on working copies (cur_addr, remain), so start_addr and
    // length survive it and a second CMD_DUMP repeats the same transfer.
    // mem_addr is loaded only when the FSM enters RD, so it keeps its value
    // while mem_rd is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr   <= '0;
            remain     <= 16'd0;
            mem_addr   <= '0;
            tx_byte    <= 8'h00;
            abort_pend <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (next_state == RD) begin
                        cur_addr   <= start_addr;
                        remain     <= length;
                        mem_addr   <= start_addr;
                        abort_pend <= 1'b0;
                    end
                end

                CAP: begin
                    if (!abort_now) begin
                        tx_byte <= mem_data;
                    end
                end

                SEND, GUARD: begin
                    if (abort_now) begin
                        abort_pend <= 1'b1;
                    end
                end

                WAITTX: begin
                    if (abort_now) begin
                        abort_pend <= 1'b1;
                    end
                    if (!tx_busy) begin
                        remain   <= remain_dec;
                        cur_addr <= cur_addr + 1'b1;
                        if (next_state == RD) begin
                            mem_addr <= cur_addr + 1'b1;
                        end
                    end
                end

                FIN: begin
                    abort_pend <= 1'b0;
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_dump_ctrl
//
// Purpose:
//   Self-checking bench for bram_dump_ctrl with the default parameters.
//   The bench models two peripherals:
//     - a BRAM with a one-cycle read latency that holds BRAM[i] = i[7:0]
//     - a UART transmitter that raises tx_busy after each send, with a
//       programmable delay and busy duration
//   A monitor samples the DUT on the falling edge and logs reads, sends and
//   done pulses with their cycle numbers. The table-driven dumps and the
//   hand-written corner sequences check against those logs.
// ---------------------------------------------------------------------------
module tb_bram_dump_ctrl;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_byte;
    logic              rx_ready;
    logic [7:0]        tx_byte;
    logic              tx_send;
    logic              tx_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              active;
    logic              done;

    bram_dump_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .tx_byte  (tx_byte),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .active   (active),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- peripheral models ----------------
    logic [7:0] bram [DEPTH];
    int         cyc;
    int         busy_delay;
    int         busy_len;
    int         since;        // cycles since the last tx_send, 0 = none yet

    initial begin
        for (int i = 0; i < DEPTH; i++) bram[i] = 8'(i);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= bram[mem_addr];
    end

    always @(posedge clk or posedge reset) begin
        if (reset)            since <= 0;
        else if (tx_send)     since <= 1;
        else if (since != 0 && since < 1000) since <= since + 1;
    end

    assign tx_busy = (since >= 1 + busy_delay) && (since <= busy_delay + busy_len);

    // ---------------- monitor ----------------
    logic [ADDR_W-1:0] rd_q[$];
    int                rd_cyc_q[$];
    logic [7:0]        tx_q[$];
    int                tx_cyc_q[$];
    int                done_cyc_q[$];
    int                act_cnt;

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_q.push_back(mem_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (tx_send) begin
            tx_q.push_back(tx_byte);
            tx_cyc_q.push_back(cyc);
        end
        if (done)   done_cyc_q.push_back(cyc);
        if (active) act_cnt <= act_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int n_cmp;
    int n_err;
    int last_rx_cyc;

    task automatic check(input string name, input longint actual, input longint expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        tick();
        rx_byte     = b;
        rx_ready    = 1'b1;
        last_rx_cyc = cyc;
        tick();
        rx_ready    = 1'b0;
    endtask

    task automatic set_regs(input logic [7:0] ah, input logic [7:0] al,
                            input logic [7:0] nh, input logic [7:0] nl);
        send_rx(8'h41); send_rx(ah); send_rx(al);
        send_rx(8'h4E); send_rx(nh); send_rx(nl);
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        for (int i = 0; i < budget && done_cyc_q.size() <= base; i++) tick();
        tick();
        check(name, done_cyc_q.size() - base, 1);
    endtask

    // Counts sent bytes that differ from BRAM at the read address, plus
    // read addresses that do not follow first, first+1, ... modulo DEPTH.
    function automatic int data_errs(input int rb, input int tb_, input int n,
                                     input int first);
        int e = 0;
        for (int k = 0; k < n; k++) begin
            if (rb + k >= rd_q.size() || tb_ + k >= tx_q.size()) begin
                e++;
            end else begin
                if (int'(rd_q[rb + k]) != (first + k) % DEPTH) e++;
                if (tx_q[tb_ + k] != bram[rd_q[rb + k]])       e++;
            end
        end
        return e;
    endfunction

    // ---------------- table of dumps ----------------
    typedef struct {
        logic [7:0]        a_hi, a_lo, n_hi, n_lo;
        bit                program_regs;
        int                blen;
        int                exp_cnt;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rb, tb_, db, ab;

        vecs[0] = '{8'h03, 8'hFE, 8'h00, 8'h04, 1'b1, 3, 4, 10'h3FE, 10'h001};
        vecs[1] = '{8'h00, 8'h10, 8'h00, 8'h01, 1'b1, 0, 1, 10'h010, 10'h010};
        vecs[2] = '{8'h44, 8'h58, 8'h00, 8'h03, 1'b1, 2, 3, 10'h058, 10'h05A};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1, 3, 10'h058, 10'h05A};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 8'h02, 1'b1, 0, 2, 10'h3FF, 10'h000};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 0, 0, 10'h000, 10'h000};

        n_cmp = 0; n_err = 0; cyc = 0; act_cnt = 0; last_rx_cyc = 0;
        rx_byte = 8'h00; rx_ready = 1'b0; busy_delay = 0; busy_len = 10;

        // ---- reset values ----
        reset = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {tx_byte, tx_send, mem_rd, mem_addr, active, done}, 0);
        reset = 1'b0;
        tick();

        // ---- full default dump: 1024 bytes, latency, one done ----
        rb = rd_q.size(); tb_ = tx_q.size(); db = done_cyc_q.size();
        send_rx(8'h44);
        wait_done("full_done", db, 20000);
        check("full_tx_count", tx_q.size() - tb_, 1024);
        check("full_rd_count", rd_q.size() - rb, 1024);
        check("full_data", data_errs(rb, tb_, 1024, 0), 0);
        check("lat_mem_rd", rd_cyc_q[rb] - last_rx_cyc, 1);
        check("lat_tx_send", tx_cyc_q[tb_] - last_rx_cyc, 3);
        check("full_last_byte", tx_q[tx_q.size() - 1], 8'hFF);

        // ---- table-driven dumps ----
        for (int v = 0; v < 6; v++) begin
            busy_delay = 0;
            busy_len   = vecs[v].blen;
            if (vecs[v].program_regs)
                set_regs(vecs[v].a_hi, vecs[v].a_lo, vecs[v].n_hi, vecs[v].n_lo);
            rb = rd_q.size(); tb_ = tx_q.size(); db = done_cyc_q.size(); ab = act_cnt;
            send_rx(8'h44);
            wait_done($sformatf("vec%0d_done", v), db, 2000);
            check($sformatf("vec%0d_tx_count", v), tx_q.size() - tb_, vecs[v].exp_cnt);
            check($sformatf("vec%0d_rd_count", v), rd_q.size() - rb, vecs[v].exp_cnt);
            if (vecs[v].exp_cnt > 0) begin
                check($sformatf("vec%0d_first_addr", v), rd_q[rb], vecs[v].exp_first);
                check($sformatf("vec%0d_last_addr", v), rd_q[rd_q.size() - 1], vecs[v].exp_last);
                check($sformatf("vec%0d_data", v),
                      data_errs(rb, tb_, vecs[v].exp_cnt, int'(vecs[v].exp_first)), 0);
            end else begin
                check($sformatf("vec%0d_active_cycles", v), act_cnt - ab, 0);
                check($sformatf("vec%0d_done_latency", v), done_cyc_q[db] - last_rx_cyc, 1);
            end
        end

        // ---- abort while in RD: D then X on consecutive cycles ----
        set_regs(8'h00, 8'h20, 8'h00, 8'h08);
        busy_len = 4;
        rb = rd_q.size(); tb_ = tx_q.size(); db = done_cyc_q.size();
        tick();
        rx_byte = 8'h44; rx_ready = 1'b1;
        tick();
        rx_byte = 8'h58;
        tick();
        rx_ready = 1'b0;
        wait_done("abort_rd_done", db, 200);
        check("abort_rd_tx_count", tx_q.size() - tb_, 0);
        check("abort_rd_rd_count", rd_q.size() - rb, 1);

        // ---- abort while the 3rd byte is in WAITTX ----
        set_regs(8'h00, 8'h00, 8'h00, 8'h10);
        busy_len = 10;
        rb = rd_q.size(); tb_ = tx_q.size(); db = done_cyc_q.size();
        send_rx(8'h44);
        for (int i = 0; i < 500 && tx_q.size() - tb_ < 3; i++) tick();
        repeat (3) tick();
        send_rx(8'h58);
        wait_done("abort_wait_done", db, 500);
        check("abort_wait_tx_count", tx_q.size() - tb_, 3);
        check("abort_wait_rd_count", rd_q.size() - rb, 3);
        if (tx_q.size() - tb_ == 3 && done_cyc_q.size() > db)
            check("abort_wait_done_cycle", done_cyc_q[db] - tx_cyc_q[tb_ + 2], 12);
        check("abort_wait_active", active, 0);

        // ---- busy lags send by one cycle, then high for 5 cycles ----
        set_regs(8'h00, 8'h40, 8'h00, 8'h03);
        busy_delay = 1; busy_len = 5;
        rb = rd_q.size(); tb_ = tx_q.size(); db = done_cyc_q.size();
        send_rx(8'h44);
        wait_done("lag_done", db, 500);
        check("lag_tx_count", tx_q.size() - tb_, 3);
        check("lag_rd_count", rd_q.size() - rb, 3);
        check("lag_data", data_errs(rb, tb_, 3, 'h40), 0);
        if (rd_q.size() - rb == 3 && tx_q.size() - tb_ == 3) begin
            check("lag_gap1", rd_cyc_q[rb + 1] - tx_cyc_q[tb_], 8);
            check("lag_gap2", rd_cyc_q[rb + 2] - tx_cyc_q[tb_ + 1], 8);
        end
        busy_delay = 0;

        // ---- reset in the middle of a dump ----
        set_regs(8'h00, 8'h00, 8'h00, 8'h20);
        busy_len = 4;
        tb_ = tx_q.size();
        send_rx(8'h44);
        for (int i = 0; i < 500 && tx_q.size() - tb_ < 2; i++) tick();
        tick();
        reset = 1'b1;
        #1;
        check("midreset_outputs", {tx_byte, tx_send, mem_rd, mem_addr, active, done}, 0);
        tick();
        reset = 1'b0;
        rb = rd_q.size(); tb_ = tx_q.size(); db = done_cyc_q.size();
        repeat (40) tick();
        check("midreset_no_tx", tx_q.size() - tb_, 0);
        check("midreset_no_done", done_cyc_q.size() - db, 0);
        check("midreset_no_rd", rd_q.size() - rb, 0);
        // start_addr went back to 0 with reset
        send_rx(8'h4E); send_rx(8'h00); send_rx(8'h01);
        send_rx(8'h44);
        wait_done("postreset_done", db, 200);
        check("postreset_addr", (rd_q.size() > rb) ? rd_q[rb] : 10'h3FF, 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
